multicycle_control: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath; producer of the 2-bit ALU-op code consumed by the ALU-control decoder.

---
 rtl/multicycle_control_pkg.sv | 59 +++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control_mem_wait_timer.sv | 33 +++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and datapath mux codes.
// The ADDI states exist only when MULTICYCLE_ADDI_EN is defined.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9
`ifdef MULTICYCLE_ADDI_EN
    ,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State-decoded (Moore) part of the control word; FETCH's irWrite/pcWrite are gated separately.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle FSM (master) and the datapath/memory side (slave).
interface multicycle_control_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] i_opcode;
  logic                i_memReady;
  logic                o_pcWrite;
  logic                o_pcWriteCond;
  logic                o_iorD;
  logic                o_memRead;
  logic                o_memWrite;
  logic                o_irWrite;
  logic                o_memToReg;
  logic                o_regDst;
  logic                o_regWrite;
  logic                o_aluSrcA;
  logic [1:0]          o_aluSrcB;
  logic [1:0]          o_pcSource;
  logic [1:0]          o_aluOp;
  logic                o_illegal;
  logic                o_memErr;
  logic [3:0]          o_state;

  modport master (
    input  i_opcode, i_memReady,
    output o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_pcSource,
           o_aluOp, o_illegal, o_memErr, o_state
  );

  modport slave (
    output i_opcode, i_memReady,
    input  o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_pcSource,
           o_aluOp, o_illegal, o_memErr, o_state
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle that hits MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables the timeout (wait forever).
module multicycle_control_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Outside a wait, on ready, or on timeout the count returns to zero, so every access starts fresh.
  always_comb begin
    cnt_d     = '0;
    o_timeout = 1'b0;
    if ((MEM_TIMEOUT > 0) && i_wait && !i_ready) begin
      if (cnt_q == LIMIT) o_timeout = 1'b1;
      else                cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath, with memory-ready stalls and a bounded wait.
// Define MULTICYCLE_ADDI_EN to accept addi (opcode 0x08); otherwise 0x08 decodes as illegal.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                  i_clk,
  input logic                  i_rst,
  multicycle_control_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   lw_q;
  logic   in_wait, timeout, illegal, fetch_done;

  function automatic ctrl_t moore(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.memRead  = 1'b1;
        c.aluSrcB  = SRCB_FOUR;
        c.aluOp    = ALUOP_ADD;
        c.pcSource = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.aluSrcB = SRCB_IMM_SH;
        c.aluOp   = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      ST_MEM_WB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      ST_EXECUTE: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluOp   = ALUOP_FUNC;
      end
      ST_R_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      ST_BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluSrcB     = SRCB_B;
        c.aluOp       = ALUOP_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDI_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        c.regWrite = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) || (state_q == ST_MEM_WRITE);

  multicycle_control_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wait    (in_wait),
    .i_ready   (bus.i_memReady),
    .o_timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.i_memReady) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (bus.i_opcode)
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_SW):  state_d = ST_MEM_ADDR;
          OPCODE_W'(OP_R):   state_d = ST_EXECUTE;
          OPCODE_W'(OP_BEQ): state_d = ST_BRANCH;
          OPCODE_W'(OP_J):   state_d = ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OPCODE_W'(OP_ADDI): state_d = ST_ADDI_EXEC;
`else
          OPCODE_W'(OP_ADDI): begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
`endif
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR:  state_d = lw_q ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ: begin
        if (bus.i_memReady)  state_d = ST_MEM_WB;
        else if (timeout)    state_d = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        if (bus.i_memReady || timeout) state_d = ST_FETCH;
      end
      ST_EXECUTE:   state_d = ST_R_WB;
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
`endif
      default:      state_d = ST_FETCH;
    endcase
  end

  // Moore outputs are registered from the next state so they are glitch-free in the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_FETCH;
      ctrl_q  <= moore(ST_FETCH);
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore(state_d);
      if (state_q == ST_DECODE) lw_q <= (bus.i_opcode == OPCODE_W'(OP_LW));
    end
  end

  assign fetch_done = (state_q == ST_FETCH) && bus.i_memReady && !i_rst;

  assign bus.o_pcWrite     = ctrl_q.pcWrite | fetch_done;
  assign bus.o_irWrite     = fetch_done;
  assign bus.o_pcWriteCond = ctrl_q.pcWriteCond;
  assign bus.o_iorD        = ctrl_q.iorD;
  assign bus.o_memRead     = ctrl_q.memRead;
  assign bus.o_memWrite    = ctrl_q.memWrite;
  assign bus.o_memToReg    = ctrl_q.memToReg;
  assign bus.o_regDst      = ctrl_q.regDst;
  assign bus.o_regWrite    = ctrl_q.regWrite;
  assign bus.o_aluSrcA     = ctrl_q.aluSrcA;
  assign bus.o_aluSrcB     = ctrl_q.aluSrcB;
  assign bus.o_pcSource    = ctrl_q.pcSource;
  assign bus.o_aluOp       = ctrl_q.aluOp;
  assign bus.o_illegal     = illegal && !i_rst;
  assign bus.o_memErr      = timeout && !i_rst;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected per-cycle
// control-word trace from the opcode and the memory wait lengths, then replayed against the DUT.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int T = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(6)) bus();

  multicycle_control #(.OPCODE_W(6), .MEM_TIMEOUT(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [21:0] v;
    bit          rdy;
  } step_t;

  step_t plan[$];

  function automatic logic [21:0] obs();
    return {bus.o_pcWrite, bus.o_pcWriteCond, bus.o_iorD, bus.o_memRead, bus.o_memWrite,
            bus.o_irWrite, bus.o_memToReg, bus.o_regDst, bus.o_regWrite, bus.o_aluSrcA,
            bus.o_aluSrcB, bus.o_pcSource, bus.o_aluOp, bus.o_illegal, bus.o_memErr, bus.o_state};
  endfunction

  function automatic logic [21:0] pk(bit pcW, bit pcWC, bit iorD, bit mR, bit mW, bit irW,
                                     bit m2r, bit rDst, bit rW, bit srcA, logic [1:0] srcB,
                                     logic [1:0] pcS, logic [1:0] aop, bit ill, bit err,
                                     logic [3:0] st);
    return {pcW, pcWC, iorD, mR, mW, irW, m2r, rDst, rW, srcA, srcB, pcS, aop, ill, err, st};
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [21:0] v, input bit r);
    step_t s;
    s.v   = v;
    s.rdy = r;
    plan.push_back(s);
  endtask

  // Expected trace of one instruction; fw/mw = not-ready cycles before memory answers.
  task automatic plan_instr(input logic [5:0] op, input int fw, input int mw);
    bit legal;
    for (int i = 0; i < fw && i < T; i++)
      push(pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,ST_FETCH), 1'b0);
    if (fw > T) begin
      push(pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1,ST_FETCH), 1'b0);
      return;
    end
    push(pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,ST_FETCH), 1'b1);
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef MULTICYCLE_ADDI_EN
    if (op == 6'h08) legal = 1'b1;
`endif
    push(pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legal,0,ST_DECODE), rnd_bit());
    if (!legal) return;
    if (op == 6'h23 || op == 6'h2B) begin
      push(pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,ST_MEM_ADDR), rnd_bit());
      if (op == 6'h23) begin
        for (int i = 0; i < mw && i < T; i++)
          push(pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,ST_MEM_READ), 1'b0);
        if (mw > T) begin
          push(pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,ST_MEM_READ), 1'b0);
          return;
        end
        push(pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,ST_MEM_READ), 1'b1);
        push(pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,ST_MEM_WB), rnd_bit());
      end else begin
        for (int i = 0; i < mw && i < T; i++)
          push(pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,ST_MEM_WRITE), 1'b0);
        if (mw > T) begin
          push(pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,ST_MEM_WRITE), 1'b0);
          return;
        end
        push(pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,ST_MEM_WRITE), 1'b1);
      end
    end else if (op == 6'h00) begin
      push(pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0,0,ST_EXECUTE), rnd_bit());
      push(pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,ST_R_WB), rnd_bit());
    end else if (op == 6'h04) begin
      push(pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,ST_BRANCH), rnd_bit());
    end else if (op == 6'h02) begin
      push(pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0,0,ST_JUMP), rnd_bit());
    end
`ifdef MULTICYCLE_ADDI_EN
    else if (op == 6'h08) begin
      push(pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,ST_ADDI_EXEC), rnd_bit());
      push(pk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,ST_ADDI_WB), rnd_bit());
    end
`endif
  endtask

  // Called #1 after a rising edge; replays up to max_steps planned cycles, then drops the rest.
  task automatic run_plan(input string name, input logic [5:0] op, input int max_steps);
    int cyc = 0;
    bus.i_opcode = op;
    while (plan.size() > 0 && cyc < max_steps) begin
      step_t s;
      logic [21:0] got;
      s = plan.pop_front();
      bus.i_memReady = s.rdy;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== s.v) begin
        errors++;
        $display("FAIL %s op=%h cyc=%0d got=%h exp=%h", name, op, cyc, got, s.v);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    plan.delete();
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    plan_instr(op, fw, mw);
    run_plan(name, op, 1000);
  endtask

  task automatic test_reset();
    logic [21:0] exp_rst;
    exp_rst = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,ST_FETCH);
    rst = 1'b1;
    bus.i_memReady = 1'b1;
    bus.i_opcode = 6'h00;
    #2;
    checks++;
    if (obs() !== exp_rst) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", obs(), exp_rst);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== exp_rst) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), exp_rst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    do_instr("rtype", 6'h00, 0, 0);
  endtask

  task automatic test_lw_wait();
    do_instr("lw_wait3", 6'h23, 0, 3);
  endtask

  task automatic test_branch_jump();
    do_instr("beq", 6'h04, 0, 0);
    do_instr("j", 6'h02, 0, 0);
  endtask

  task automatic test_timeouts();
    do_instr("sw_timeout", 6'h2B, 0, 40);
    do_instr("fetch_timeout", 6'h00, 20, 0);
    do_instr("lw_ready_at_limit", 6'h23, 2, T);
    do_instr("sw_ready_at_limit", 6'h2B, T, T);
  endtask

  task automatic test_illegal_addi();
    do_instr("addi", 6'h08, 0, 0);
    do_instr("illegal", 6'h3F, 1, 0);
  endtask

  task automatic test_reset_mid_access();
    logic [21:0] exp_rst;
    exp_rst = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,ST_FETCH);
    plan_instr(6'h23, 0, 100);
    run_plan("pre_reset_lw", 6'h23, 6);
    #2;
    bus.i_memReady = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== exp_rst) begin
      errors++;
      $display("FAIL reset_mid_read got=%h exp=%h", obs(), exp_rst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_instr("after_reset_j", 6'h02, T, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw, pick;
      pick = int'($urandom_range(0, 7));
      op = (pick == 7) ? 6'($urandom) : ops[pick];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 6) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      do_instr("random", op, fw, mw);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_jump();
    test_timeouts();
    test_illegal_addi();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
